io_ctrl: RTL and testbench

IO_CTRL -- requirements
Module: io_ctrl

---
 rtl/io_ctrl_pkg.sv | 37 +++
 rtl/io_ctrl_if.sv | 13 +
 rtl/io_ctrl_debouncer.sv | 63 ++++++
 rtl/io_ctrl.sv | 98 +++++++++
 tb/tb_io_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_ctrl_pkg.sv
// Shared project constants: bus width and memory-mapped I/O addresses,
// plus the address decoder used by the I/O controller.
package io_ctrl_pkg;

    localparam int DBITS = 32;

    localparam logic [31:0] ADDR_HEX   = 32'hF000_0000;
    localparam logic [31:0] ADDR_LEDR  = 32'hF000_0004;
    localparam logic [31:0] ADDR_LEDG  = 32'hF000_0008;
    localparam logic [31:0] ADDR_KEY   = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW    = 32'hF000_0014;
    localparam logic [31:0] ADDR_KSTAT = 32'hF000_0018;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_HEX,
        SEL_LEDR,
        SEL_LEDG,
        SEL_KEY,
        SEL_SW,
        SEL_KSTAT
    } io_sel_e;

    // Full 32-bit compare so aliases of the I/O page never hit.
    function automatic io_sel_e decode_addr(input logic [31:0] a);
        case (a)
            ADDR_HEX:   return SEL_HEX;
            ADDR_LEDR:  return SEL_LEDR;
            ADDR_LEDG:  return SEL_LEDG;
            ADDR_KEY:   return SEL_KEY;
            ADDR_SW:    return SEL_SW;
            ADDR_KSTAT: return SEL_KSTAT;
            default:    return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/io_ctrl_if.sv
// CPU memory-stage load/store port into the I/O controller.
interface io_ctrl_if import io_ctrl_pkg::*; #(
    parameter int DBITS = io_ctrl_pkg::DBITS
);
    logic             we;
    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] wdata;
    logic [DBITS-1:0] rdata;
    logic             is_io;

    modport master (output we, addr, wdata, input rdata, is_io);
    modport slave  (input we, addr, wdata, output rdata, is_io);
endinterface

// File: rtl/io_ctrl_debouncer.sv
// Per-bit 2-flop synchronizer followed by a consecutive-sample debouncer.
// rise_o flags bits whose accepted value goes 0->1 at the coming edge.
module debouncer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_BITS        = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [WIDTH-1:0] rise_o
);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CNT_SAT  = '1;

    logic [WIDTH-1:0]    sync1_q, sync2_q;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [CNT_BITS-1:0] cnt_q [WIDTH];
    logic [CNT_BITS-1:0] cnt_d [WIDTH];

    // Two-stage synchronizer for the asynchronous board inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive differing samples; accept on the last one, saturate otherwise.
    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == acc_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                acc_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CNT_SAT) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Accepted value and counters; reset discards any partial count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            acc_q <= acc_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign dout_o = acc_q;
    assign rise_o = acc_d & ~acc_q;

endmodule

// File: rtl/io_ctrl.sv
// Memory-mapped board I/O: HEX/LEDR/LEDG output registers, debounced
// KEY/SW inputs and sticky key-press status (write-1-to-clear).
module io_ctrl import io_ctrl_pkg::*; #(
    parameter int DBITS           = io_ctrl_pkg::DBITS,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int DB_CNT_BITS     = 17
) (
    input  logic        clk,
    input  logic        reset,
    io_ctrl_if.slave    bus,
    input  logic [3:0]  key_n,
    input  logic [9:0]  sw_in,
    output logic [15:0] hex_out,
    output logic [9:0]  ledr_out,
    output logic [7:0]  ledg_out
);
    io_sel_e     sel;
    logic [31:0] addr32;
    logic [15:0] hex_q, hex_d;
    logic [9:0]  ledr_q, ledr_d;
    logic [7:0]  ledg_q, ledg_d;
    logic [3:0]  kstat_q, kstat_d, kstat_clr;
    logic [3:0]  key_db, key_rise;
    logic [9:0]  sw_db, sw_rise_unused;

    assign addr32 = 32'(bus.addr);
    assign sel    = decode_addr(addr32);

    // Keys are inverted first so the debounced state reads 1 = pressed.
    debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_BITS(DB_CNT_BITS)) u_key_db (
        .clk    (clk),
        .reset  (reset),
        .din_i  (~key_n),
        .dout_o (key_db),
        .rise_o (key_rise)
    );

    debouncer #(.WIDTH(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_BITS(DB_CNT_BITS)) u_sw_db (
        .clk    (clk),
        .reset  (reset),
        .din_i  (sw_in),
        .dout_o (sw_db),
        .rise_o (sw_rise_unused)
    );

    // Store decode; a press landing on the same edge as its clear keeps the bit set.
    always_comb begin
        hex_d     = hex_q;
        ledr_d    = ledr_q;
        ledg_d    = ledg_q;
        kstat_clr = '0;
        if (bus.we) begin
            case (sel)
                SEL_HEX:   hex_d     = bus.wdata[15:0];
                SEL_LEDR:  ledr_d    = bus.wdata[9:0];
                SEL_LEDG:  ledg_d    = bus.wdata[7:0];
                SEL_KSTAT: kstat_clr = bus.wdata[3:0];
                default:   ;
            endcase
        end
        kstat_d = (kstat_q & ~kstat_clr) | key_rise;
    end

    // Output and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_q   <= '0;
            ledr_q  <= '0;
            ledg_q  <= '0;
            kstat_q <= '0;
        end else begin
            hex_q   <= hex_d;
            ledr_q  <= ledr_d;
            ledg_q  <= ledg_d;
            kstat_q <= kstat_d;
        end
    end

    // Zero-latency load mux; unmapped addresses read as 0.
    always_comb begin
        bus.rdata = '0;
        bus.is_io = (sel != SEL_NONE);
        case (sel)
            SEL_HEX:   bus.rdata = DBITS'(hex_q);
            SEL_LEDR:  bus.rdata = DBITS'(ledr_q);
            SEL_LEDG:  bus.rdata = DBITS'(ledg_q);
            SEL_KEY:   bus.rdata = DBITS'(key_db);
            SEL_SW:    bus.rdata = DBITS'(sw_db);
            SEL_KSTAT: bus.rdata = DBITS'(kstat_q);
            default:   bus.rdata = '0;
        endcase
    end

    assign hex_out  = hex_q;
    assign ledr_out = ledr_q;
    assign ledg_out = ledg_q;

endmodule

// File: tb/tb_io_ctrl.sv
// Directed scenarios plus a randomized phase, checked against a behavioural
// model: 2-sample input delay, then acceptance once the last N delayed
// samples all disagree with the accepted value.
module tb_io_ctrl;
    import io_ctrl_pkg::*;

    localparam int N = 8;

    logic        clk;
    logic        reset;
    logic [3:0]  key_n;
    logic [9:0]  sw_in;
    logic [15:0] hex_out;
    logic [9:0]  ledr_out;
    logic [7:0]  ledg_out;

    io_ctrl_if #(.DBITS(32)) bus ();

    io_ctrl #(.DBITS(32), .DEBOUNCE_CYCLES(N), .DB_CNT_BITS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .key_n    (key_n),
        .sw_in    (sw_in),
        .hex_out  (hex_out),
        .ledr_out (ledr_out),
        .ledg_out (ledg_out)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_hex;
    logic [9:0]  m_ledr, m_sw;
    logic [7:0]  m_ledg;
    logic [3:0]  m_key, m_kstat;
    logic [13:0] m_p1, m_p2;
    logic [13:0] hist[$];

    logic [31:0] rd_addrs [7] = '{ADDR_HEX, ADDR_LEDR, ADDR_LEDG, ADDR_KEY,
                                  ADDR_SW, ADDR_KSTAT, 32'hF000_0020};
    logic [31:0] rnd_addrs [8] = '{ADDR_HEX, ADDR_LEDR, ADDR_LEDG, ADDR_KEY,
                                   ADDR_SW, ADDR_KSTAT, 32'hF000_000C, 32'hF000_0020};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a)
            ADDR_HEX:   return {16'h0, m_hex};
            ADDR_LEDR:  return {22'h0, m_ledr};
            ADDR_LEDG:  return {24'h0, m_ledg};
            ADDR_KEY:   return {28'h0, m_key};
            ADDR_SW:    return {22'h0, m_sw};
            ADDR_KSTAT: return {28'h0, m_kstat};
            default:    return 32'h0;
        endcase
    endfunction

    function automatic logic m_isio(input logic [31:0] a);
        return (a == ADDR_HEX) || (a == ADDR_LEDR) || (a == ADDR_LEDG) ||
               (a == ADDR_KEY) || (a == ADDR_SW) || (a == ADDR_KSTAT);
    endfunction

    task automatic model_reset();
        m_hex = '0; m_ledr = '0; m_ledg = '0; m_sw = '0; m_key = '0; m_kstat = '0;
        m_p1 = '0; m_p2 = '0;
        hist.delete();
    endtask

    // One clock edge: capture stimulus, advance the model, land 1 time unit past the edge.
    task automatic step();
        logic [13:0] raw, acc, nacc;
        logic        cap_we, all_diff;
        logic [31:0] cap_a, cap_d;
        logic [3:0]  clr;
        raw    = {sw_in, ~key_n};
        cap_we = bus.we;
        cap_a  = bus.addr;
        cap_d  = bus.wdata;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            hist.push_back(m_p2);
            if (hist.size() > N) void'(hist.pop_front());
            acc  = {m_sw, m_key};
            nacc = acc;
            if (hist.size() == N) begin
                for (int b = 0; b < 14; b++) begin
                    all_diff = 1'b1;
                    foreach (hist[j]) if (hist[j][b] == acc[b]) all_diff = 1'b0;
                    if (all_diff) nacc[b] = ~acc[b];
                end
            end
            m_p2 = m_p1;
            m_p1 = raw;
            clr = (cap_we && cap_a == ADDR_KSTAT) ? cap_d[3:0] : 4'h0;
            m_kstat = (m_kstat & ~clr) | (nacc[3:0] & ~acc[3:0]);
            m_key = nacc[3:0];
            m_sw  = nacc[13:4];
            if (cap_we) begin
                case (cap_a)
                    ADDR_HEX:  m_hex  = cap_d[15:0];
                    ADDR_LEDR: m_ledr = cap_d[9:0];
                    ADDR_LEDG: m_ledg = cap_d[7:0];
                    default:   ;
                endcase
            end
        end
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        step();
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
        bus.we = 1'b0; bus.addr = a;
        #1;
        check(tag, bus.rdata, exp);
        check({tag, "_model"}, bus.rdata, m_read(a));
    endtask

    task automatic check_outs();
        check("hex_out", {16'h0, hex_out}, {16'h0, m_hex});
        check("ledr_out", {22'h0, ledr_out}, {22'h0, m_ledr});
        check("ledg_out", {24'h0, ledg_out}, {24'h0, m_ledg});
    endtask

    task automatic check_reads();
        bus.we = 1'b0;
        foreach (rd_addrs[i]) begin
            bus.addr = rd_addrs[i];
            #1;
            check($sformatf("rdata_%h", rd_addrs[i]), bus.rdata, m_read(rd_addrs[i]));
            check($sformatf("is_io_%h", rd_addrs[i]), {31'h0, bus.is_io}, {31'h0, m_isio(rd_addrs[i])});
        end
    endtask

    initial begin
        reset = 1'b1; key_n = 4'hF; sw_in = '0;
        bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        model_reset();
        #1;
        step(); step();
        check("rst_hex", {16'h0, hex_out}, 32'h0);
        check("rst_ledr", {22'h0, ledr_out}, 32'h0);
        check_outs();
        check_reads();
        reset = 1'b0;
        step();

        // Output register stores and same-cycle readback.
        store(ADDR_HEX, 32'h0000_ABCD);
        check("hex_abcd", {16'h0, hex_out}, 32'h0000_ABCD);
        store(ADDR_LEDR, 32'h0000_03FF);
        check("ledr_3ff", {22'h0, ledr_out}, 32'h0000_03FF);
        store(ADDR_LEDG, 32'h0000_00A5);
        check("ledg_a5", {24'h0, ledg_out}, 32'h0000_00A5);
        rd(ADDR_HEX, "rd_hex", 32'h0000_ABCD);

        // Switch acceptance exactly 2 + N edges after the change.
        sw_in = 10'h155;
        for (int c = 1; c <= 12; c++) begin
            step();
            rd(ADDR_SW, $sformatf("sw_c%0d", c), (c >= 10) ? 32'h155 : 32'h0);
        end

        // Key press with a one-sample glitch restarting the count.
        for (int c = 1; c <= 16; c++) begin
            key_n = (c == 5) ? 4'hF : 4'hE;
            step();
            rd(ADDR_KEY, $sformatf("key_c%0d", c), (c >= 15) ? 32'h1 : 32'h0);
        end
        rd(ADDR_KSTAT, "kstat_set", 32'h1);

        // Release, then write-1-to-clear.
        key_n = 4'hF;
        repeat (12) step();
        rd(ADDR_KEY, "key_released", 32'h0);
        rd(ADDR_KSTAT, "kstat_sticky", 32'h1);
        store(ADDR_KSTAT, 32'h1);
        rd(ADDR_KSTAT, "kstat_cleared", 32'h0);

        // Press accepted on the same edge as a clear: set wins.
        key_n = 4'hE;
        repeat (N + 1) step();
        rd(ADDR_KEY, "key_pre", 32'h0);
        store(ADDR_KSTAT, 32'h1);
        rd(ADDR_KEY, "key_same_edge", 32'h1);
        rd(ADDR_KSTAT, "kstat_set_wins", 32'h1);
        key_n = 4'hF;
        repeat (12) step();
        store(ADDR_KSTAT, 32'hF);

        // Asynchronous reset mid-debounce discards the partial count.
        store(ADDR_LEDR, 32'h3FF);
        sw_in = 10'h2AA;
        repeat (5) step();
        reset = 1'b1;
        #1;
        check("arst_ledr", {22'h0, ledr_out}, 32'h0);
        check("arst_hex", {16'h0, hex_out}, 32'h0);
        check("arst_ledg", {24'h0, ledg_out}, 32'h0);
        model_reset();
        rd(ADDR_SW, "arst_sw", 32'h0);
        rd(ADDR_KSTAT, "arst_kstat", 32'h0);
        step();
        reset = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            step();
            rd(ADDR_SW, $sformatf("post_rst_sw_c%0d", c), (c >= 10) ? 32'h2AA : 32'h0);
        end
        rd(ADDR_KSTAT, "post_rst_kstat", 32'h0);

        // Unmapped load and store.
        store(ADDR_HEX, 32'h1234);
        store(ADDR_LEDR, 32'h155);
        store(ADDR_LEDG, 32'h3C);
        rd(32'hF000_0020, "unmapped_rd", 32'h0);
        check("unmapped_rd_isio", {31'h0, bus.is_io}, 32'h0);
        bus.we = 1'b1; bus.addr = 32'hF000_000C; bus.wdata = 32'hFFFF_FFFF;
        #1;
        check("unmapped_wr_isio", {31'h0, bus.is_io}, 32'h0);
        check("unmapped_wr_rdata", bus.rdata, 32'h0);
        step();
        bus.we = 1'b0;
        check("unmapped_hex", {16'h0, hex_out}, 32'h1234);
        check("unmapped_ledr", {22'h0, ledr_out}, 32'h155);
        check("unmapped_ledg", {24'h0, ledg_out}, 32'h3C);

        // Randomized traffic against the model.
        for (int it = 0; it < 400; it++) begin
            check_outs();
            check_reads();
            if ($urandom_range(0, 19) == 0) key_n = 4'($urandom);
            if ($urandom_range(0, 24) == 0) sw_in = 10'($urandom);
            bus.we    = 1'($urandom_range(0, 1));
            bus.addr  = rnd_addrs[$urandom_range(0, 7)];
            bus.wdata = $urandom;
            step();
        end
        bus.we = 1'b0;
        check_outs();
        check_reads();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
